// File: rtl/yarv_pkg.sv
// Shared fetch-stage definitions: instruction size, default reset PC and the
// entry format stored in the fetch FIFO.
package yarv_pkg;

    localparam int unsigned INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Fetch addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO between the icache and decode. Flush beats push/pop,
// and the head is read straight from storage so it is always a registered value.
module fetch_fifo
    import yarv_pkg::*;
#(
    parameter int unsigned AW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned DEPTH      = 1 << AW;
    localparam logic [AW:0]   FULL_COUNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // entries are never observed and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests the icache, buffers returned
// words in fetch_fifo and hands them to decode. Redirects flush and restart.
module fetch_unit
    import yarv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_AW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        cache_valid,
    input  logic        cache_ready,
    output logic [31:0] cache_addr,
    input  logic [31:0] cache_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
);

    localparam logic [31:0] PC_STEP = 32'(INSN_BYTES);

    logic         [31:0] pc;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fire;
    fetch_entry_t        push_entry;
    fetch_entry_t        head_entry;

    // A redirect suppresses the request so nothing from the old path is pushed.
    assign cache_valid = rst_n && !redirect_valid && !fifo_full;
    assign cache_addr  = pc;
    assign fire        = cache_valid && cache_ready;

    assign push_entry.pc   = pc;
    assign push_entry.insn = cache_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= align_pc(RESET_PC);
        end else if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
        end else if (fire) begin
            pc <= pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (fire),
        .push_data(push_entry),
        .pop      (inst_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_entry)
    );

    assign inst_valid = !fifo_empty;
    assign inst_pc    = head_entry.pc;
    assign inst_data  = head_entry.insn;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction cache.
- Owns the program counter and drives the cache request/address.
- Captures returned instruction words into a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump/trap target) that flushes in-flight state and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_AW, 1, log2 of instruction FIFO depth; depth = 2^FIFO_AW (default 2 entries).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- redirect_valid  in  1  restart fetch at redirect_pc this cycle.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- cache_valid  out  1  fetch request to icache.
- cache_ready  in  1  icache hit; cache_rdata valid this same cycle.
- cache_addr  out  32  fetch address, always equal to the PC register.
- cache_rdata  in  32  instruction word for cache_addr.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_pc  out  32  PC of the head instruction.
- inst_data  out  32  head instruction word.

Behaviour:
- Reset (rst_n low at posedge):
  - pc <= RESET_PC with bits [1:0] forced to 0.
  - FIFO count <= 0, so inst_valid=0.
  - While rst_n is low, cache_valid is combinationally 0.
  - inst_pc/inst_data are don't-care while inst_valid=0.
- Request: cache_valid = rst_n && !redirect_valid && (count != 2^FIFO_AW).
  - cache_addr = pc at all times, held stable for as long as the cache is missing.
  - The icache's ready is combinational and may stay low for many cycles (miss). The unit simply holds the request.
- Hit (fire = cache_valid && cache_ready):
  - Push {pc, cache_rdata} into the FIFO tail.
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Pop (inst_valid && inst_ready): advance head. Push and pop in the same cycle keep count unchanged.
- Full: no request is issued (no full-bypass). Depth 2 sustains one instruction per cycle.
- Latency: hit in cycle N -> inst_valid with that instruction in cycle N+1 (FIFO output registered, no combinational cache->decode path).
- Redirect (redirect_valid high at posedge, rst_n high):
  - Count <= 0, head/tail pointers reset.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push occurs that cycle because cache_valid=0.
  - A pop offered in the same cycle is accepted by decode as shown, then the FIFO is flushed. Decode must ignore it per pipeline-kill rules.
  - Back-to-back redirects: the last one wins.
  - Redirect during an icache miss is legal. The cache address simply changes.
- Reset has priority over redirect; redirect has priority over push/pop.
- Count width FIFO_AW+1. No overflow/underflow is possible by construction; the bench asserts this.

Decomposition:
- Shared package (yarv_pkg): INSN_BYTES=4, default RESET_PC, and a fetch-entry struct/width constant (64 bits = pc + insn).
- One sub-module: fetch_fifo.
  - Synchronous FIFO, parameter AW, width 64, ports push/pop/flush, full/empty/head.
  - Active-low sync reset.
  - Flush has priority over push/pop.
- fetch_unit contains the PC register, request logic and fetch_fifo instance.

Test Plan:
1. RESET_PC=0x100, cache_ready=1, cache_rdata=cache_addr^32'hA5A5A5A5, inst_ready=1; release reset -> cache_addr 0x100,0x104,0x108 on consecutive cycles; inst_valid from 1 cycle after first hit; inst_pc 0x100,0x104,0x108 with matching data, one per cycle.
2. Same stimulus, inst_ready=0 -> after 2 hits cache_valid=0, cache_addr holds 0x108, count=2; raise inst_ready -> stream resumes 0x100,0x104,0x108 with no loss or duplicate.
3. cache_ready low 5 cycles at 0x104 -> cache_valid stays 1, cache_addr stays 0x104, no push; on hit 0x104 is delivered next cycle.
4. FIFO holding 2 entries, redirect_valid=1 with redirect_pc=0x2003 -> that cycle cache_valid=0; next cycle inst_valid=0 and cache_addr=0x2000; subsequent stream 0x2000,0x2004.
5. Redirect to 0xFFFFFFFC -> delivered pcs 0xFFFFFFFC then 0x00000000.
6. rst_n driven low mid-miss at pc 0x40 with FIFO non-empty -> cache_valid=0 during reset; after release inst_valid=0 and cache_addr=RESET_PC.
